// File: rtl/i2c_csr_sequencer.sv
// i2c_csr_sequencer: turns one client command into the complete I2C controller CSR access sequence.
// Latency: 6 init writes after reset; per command 1+len TFR_CMD writes, STATUS polls, ISR read, RX pops or 3-write clean.
// Backpressure: cmd_ready only in IDLE after init; response held on rsp_valid until rsp_ready.
// Ports: clk/reset_n; cmd_* command in; rsp_* status/read data out; csr_* master port to the controller CSR slave.
// Optional feature: define I2C_SEQ_RETRY_EN to re-issue NACKed transfers up to RETRIES extra times.
module i2c_csr_sequencer #(
    parameter int MAX_BYTES    = 4,
    parameter int SCL_LOW_CNT  = 250,
    parameter int SCL_HIGH_CNT = 250,
    parameter int SDA_HOLD_CNT = 30,
    parameter int TIMEOUT_CYC  = 200000,
    parameter int RETRIES      = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_rnw,
    input  logic [6:0]                     cmd_taddr,
    input  logic [$clog2(MAX_BYTES+1)-1:0] cmd_len,
    input  logic [8*MAX_BYTES-1:0]         cmd_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [1:0]                     rsp_status,
    output logic [8*MAX_BYTES-1:0]         rsp_rdata,
    output logic [3:0]                     csr_address,
    output logic                           csr_read,
    output logic                           csr_write,
    output logic [31:0]                    csr_writedata,
    input  logic [31:0]                    csr_readdata
);
    localparam int L  = $clog2(MAX_BYTES+1);
    localparam int IW = (L > 3) ? L : 3;
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    localparam int RW = $clog2(RETRIES+2);
`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [3:0] A_TFR = 4'h0, A_RX = 4'h1, A_CTRL = 4'h2, A_ISR = 4'h4;
    localparam logic [3:0] A_STAT = 4'h5, A_SCLL = 4'h8, A_SCLH = 4'h9, A_SDAH = 4'hA;
    localparam logic [1:0] ST_OK = 2'd0, ST_NACK = 2'd1, ST_ARB = 2'd2, ST_TMO = 2'd3;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_ADDR, S_DATA, S_POLL, S_POLL_CAP, S_CHK, S_CHK_CAP,
        S_RX, S_RX_CAP, S_CLEAN, S_RESP
    } state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [1:0]             st, st_n;
    logic                   live;           // low for the first cycle after reset so outputs stay 0 in reset
    logic                   accept, retry_inc, last;
    logic                   rnw_q;
    logic [6:0]             taddr_q;
    logic [L-1:0]           len_q;
    logic [8*MAX_BYTES-1:0] wdata_q, rdata_q;
    logic [TW-1:0]          tcnt;
    logic [RW-1:0]          retry_cnt;
    logic                   unused_rd;

    assign unused_rd  = ^csr_readdata[31:8];
    assign last       = (idx + IW'(1)) == IW'(len_q);
    assign rsp_status = st;
    assign rsp_rdata  = rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            idx   <= '0;
            st    <= ST_OK;
            live  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            st    <= st_n;
            live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rnw_q     <= 1'b0;
            taddr_q   <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            tcnt      <= '0;
            retry_cnt <= '0;
        end else begin
            if (accept) begin
                rnw_q     <= cmd_rnw;
                taddr_q   <= cmd_taddr;
                len_q     <= (cmd_len > L'(MAX_BYTES)) ? L'(MAX_BYTES) : cmd_len;
                wdata_q   <= cmd_wdata;
                rdata_q   <= '0;
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            if (state == S_RX_CAP)
                rdata_q[8*idx +: 8] <= csr_readdata[7:0];
            // Timeout counter runs only while polling and restarts on every POLL entry.
            if (state == S_POLL || state == S_POLL_CAP)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;
        end
    end

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        st_n          = st;
        accept        = 1'b0;
        retry_inc     = 1'b0;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        csr_address   = 4'h0;
        csr_read      = 1'b0;
        csr_write     = 1'b0;
        csr_writedata = 32'h0;
        case (state)
            S_INIT: begin
                if (live) begin
                    csr_write = 1'b1;
                    case (idx)
                        3'd0:    begin csr_address = A_CTRL; csr_writedata = 32'h0; end
                        3'd1:    begin csr_address = A_SCLL; csr_writedata = 32'(SCL_LOW_CNT); end
                        3'd2:    begin csr_address = A_SCLH; csr_writedata = 32'(SCL_HIGH_CNT); end
                        3'd3:    begin csr_address = A_SDAH; csr_writedata = 32'(SDA_HOLD_CNT); end
                        3'd4:    begin csr_address = A_ISR;  csr_writedata = 32'h1F; end
                        default: begin csr_address = A_CTRL; csr_writedata = 32'h1; end
                    endcase
                    if (idx == IW'(5)) begin
                        state_n = S_IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    st_n    = ST_OK;
                    state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                csr_write     = 1'b1;
                csr_address   = A_TFR;
                csr_writedata = {22'd0, 1'b1, (len_q == '0), taddr_q, rnw_q};
                idx_n         = '0;
                state_n       = (len_q == '0) ? S_POLL : S_DATA;
            end
            S_DATA: begin
                csr_write     = 1'b1;
                csr_address   = A_TFR;
                csr_writedata = {23'd0, last, rnw_q ? 8'h00 : wdata_q[8*idx +: 8]};
                if (last) begin
                    idx_n   = '0;
                    state_n = S_POLL;
                end else begin
                    idx_n = idx + IW'(1);
                end
            end
            S_POLL: begin
                csr_read    = 1'b1;
                csr_address = A_STAT;
                state_n     = S_POLL_CAP;
            end
            S_POLL_CAP: begin
                if (!csr_readdata[0]) begin
                    state_n = S_CHK;
                end else if (tcnt >= TW'(TIMEOUT_CYC - 1)) begin
                    st_n    = ST_TMO;
                    idx_n   = '0;
                    state_n = S_CLEAN;
                end else begin
                    state_n = S_POLL;
                end
            end
            S_CHK: begin
                csr_read    = 1'b1;
                csr_address = A_ISR;
                state_n     = S_CHK_CAP;
            end
            S_CHK_CAP: begin
                idx_n = '0;
                // Arbitration loss outranks NACK when both flags are set.
                if (csr_readdata[3]) begin
                    st_n    = ST_ARB;
                    state_n = S_CLEAN;
                end else if (csr_readdata[2]) begin
                    st_n    = ST_NACK;
                    state_n = S_CLEAN;
                end else begin
                    st_n    = ST_OK;
                    state_n = (rnw_q && len_q != '0) ? S_RX : S_RESP;
                end
            end
            S_RX: begin
                csr_read    = 1'b1;
                csr_address = A_RX;
                state_n     = S_RX_CAP;
            end
            S_RX_CAP: begin
                if (last) begin
                    idx_n   = '0;
                    state_n = S_RESP;
                end else begin
                    idx_n   = idx + IW'(1);
                    state_n = S_RX;
                end
            end
            S_CLEAN: begin
                // ISR clear, then a disable/enable pulse that flushes the controller FIFOs.
                csr_write   = 1'b1;
                csr_address = (idx == '0) ? A_ISR : A_CTRL;
                case (idx)
                    3'd0:    csr_writedata = 32'h1F;
                    3'd1:    csr_writedata = 32'h0;
                    default: csr_writedata = 32'h1;
                endcase
                if (idx == IW'(2)) begin
                    idx_n = '0;
                    if (RETRY_EN && st == ST_NACK && retry_cnt < RW'(RETRIES)) begin
                        retry_inc = 1'b1;
                        state_n   = S_ADDR;
                    end else begin
                        state_n = S_RESP;
                    end
                end else begin
                    idx_n = idx + IW'(1);
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_n = S_IDLE;
            end
            default: state_n = S_INIT;
        endcase
    end
endmodule

// File: tb/tb_i2c_csr_sequencer.sv
// tb_i2c_csr_sequencer: scoreboard bench with a behavioural CSR slave for i2c_csr_sequencer.
// Expected CSR write stream and responses are derived per command from the transaction rules.
// Monitors compare on every csr_write and every response handshake; rsp_ready is randomized.
module tb_i2c_csr_sequencer;
    localparam int MB      = 4;
    localparam int TMO     = 100;
    localparam int RETRIES = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [6:0]  cmd_taddr = '0;
    logic [2:0]  cmd_len = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic [3:0]  csr_address;
    logic        csr_read, csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;

    always #5 clk = ~clk;

    i2c_csr_sequencer #(.MAX_BYTES(MB), .TIMEOUT_CYC(TMO), .RETRIES(RETRIES)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_taddr(cmd_taddr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
    );

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        bit          tmo;
    } wr_t;

    wr_t         exp_wr[$];
    logic [33:0] exp_rsp[$];
    int checks = 0, errors = 0, cyc = 0, wr_seen = 0, rsp_seen = 0, last_tfr = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void push_wr(input logic [3:0] a, input logic [31:0] d, input bit tmo);
        wr_t w;
        w.a = a; w.d = d; w.tmo = tmo;
        exp_wr.push_back(w);
    endfunction

    function automatic void push_init();
        push_wr(4'h2, 32'd0, 0);
        push_wr(4'h8, 32'd250, 0);
        push_wr(4'h9, 32'd250, 0);
        push_wr(4'hA, 32'd30, 0);
        push_wr(4'h4, 32'h1F, 0);
        push_wr(4'h2, 32'd1, 0);
    endfunction

    always @(posedge clk) cyc++;

    // Behavioural controller CSR slave: per-command scenario set by the stimulus.
    int          busy_cfg = 0, busy_left = 0, rx_ptr = 0;
    bit          stuck_cfg = 0;
    logic [7:0]  isr_cfg = '0;
    logic [31:0] rx_cfg = '0;
    logic [31:0] rd_v;

    always @(posedge clk) begin
        rd_v = $urandom;
        if (csr_read) begin
            case (csr_address)
                4'h5: begin
                    rd_v[0] = stuck_cfg || (busy_left > 0);
                    if (!stuck_cfg && busy_left > 0) busy_left--;
                end
                4'h4: rd_v = {24'h0, isr_cfg};
                4'h1: begin
                    rd_v[7:0] = rx_cfg[8*(rx_ptr%4) +: 8];
                    rx_ptr++;
                end
                default: ;
            endcase
        end
        if (csr_write && csr_address == 4'h0 && csr_writedata[9]) begin
            busy_left = busy_cfg;
            rx_ptr    = 0;
        end
        csr_readdata <= rd_v;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // CSR monitor: write stream against the expected queue, read spacing rules.
    logic prev_rd = 1'b0;
    wr_t  got_w;
    always @(negedge clk) begin
        if (csr_read)
            chk(!csr_write && !prev_rd, "csr_read_rules", {csr_write, prev_rd}, 0);
        prev_rd = csr_read;
        if (csr_write) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                chk(0, "csr_write_unexpected", {csr_address, csr_writedata}, 0);
            end else begin
                got_w = exp_wr.pop_front();
                chk(csr_address == got_w.a && csr_writedata == got_w.d, "csr_write",
                    {csr_address, csr_writedata}, {got_w.a, got_w.d});
                if (got_w.tmo)
                    chk((cyc - last_tfr) >= TMO && (cyc - last_tfr) <= TMO + 8, "timeout_latency",
                        cyc - last_tfr, TMO);
            end
            if (csr_address == 4'h0) last_tfr = cyc;
        end
    end

    // Response monitor: hold stability and scoreboard compare on handshake.
    logic        held = 1'b0;
    logic [1:0]  h_st;
    logic [31:0] h_rd;
    logic [33:0] got_r;
    always @(negedge clk) begin
        if (held)
            chk(rsp_valid && rsp_status == h_st && rsp_rdata == h_rd, "rsp_hold",
                {rsp_valid, rsp_status, rsp_rdata}, {1'b1, h_st, h_rd});
        held = rsp_valid && !rsp_ready;
        h_st = rsp_status;
        h_rd = rsp_rdata;
        if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (exp_rsp.size() == 0) begin
                chk(0, "rsp_unexpected", {rsp_status, rsp_rdata}, 0);
            end else begin
                got_r = exp_rsp.pop_front();
                chk(rsp_status == got_r[33:32], "rsp_status", rsp_status, got_r[33:32]);
                chk(rsp_rdata == got_r[31:0], "rsp_rdata", rsp_rdata, got_r[31:0]);
            end
        end
    end

    // Reference model of one command: expected CSR writes and response, then drive it.
    task automatic issue_cmd(input bit rnw, input logic [6:0] ta, input int len, input logic [31:0] wd,
                             input logic [7:0] isr, input int busy, input bit stuck, input logic [31:0] rx);
        int n, st, att;
        logic [31:0] exp_rd;
        bit got;
        n   = (len > MB) ? MB : len;
        st  = stuck ? 3 : (isr[3] ? 2 : (isr[2] ? 1 : 0));
        att = 1;
`ifdef I2C_SEQ_RETRY_EN
        if (st == 1) att = RETRIES + 1;
`endif
        for (int a = 0; a < att; a++) begin
            push_wr(4'h0, 32'h200 | ((n == 0) ? 32'h100 : 32'h0) | (32'(ta) << 1) | 32'(rnw), 0);
            for (int i = 0; i < n; i++)
                push_wr(4'h0, ((i == n - 1) ? 32'h100 : 32'h0) | (rnw ? 32'h0 : 32'((wd >> (8 * i)) & 32'hFF)), 0);
            if (st != 0) begin
                push_wr(4'h4, 32'h1F, stuck);
                push_wr(4'h2, 32'h0, 0);
                push_wr(4'h2, 32'h1, 0);
            end
        end
        exp_rd = '0;
        if (st == 0 && rnw)
            for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = rx[8*i +: 8];
        exp_rsp.push_back({2'(st), exp_rd});
        isr_cfg = isr; busy_cfg = busy; stuck_cfg = stuck; rx_cfg = rx;

        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_taddr = ta; cmd_len = 3'(len); cmd_wdata = wd;
        got = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1; break; end
        end
        if (!got) chk(0, "cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_rnw = 1'($urandom); cmd_taddr = 7'($urandom);
        cmd_len = 3'($urandom); cmd_wdata = $urandom;
    endtask

    task automatic run_cmd(input bit rnw, input logic [6:0] ta, input int len, input logic [31:0] wd,
                           input logic [7:0] isr, input int busy, input bit stuck, input logic [31:0] rx);
        int target;
        bit got;
        target = rsp_seen + 1;
        issue_cmd(rnw, ta, len, wd, isr, busy, stuck, rx);
        got = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (rsp_seen >= target) begin got = 1; break; end
        end
        if (!got) chk(0, "rsp_wait_timeout", rsp_seen, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    logic [7:0] isr_tab[7] = '{8'h00, 8'h03, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h00};
    int base;

    initial begin
        push_init();
        repeat (3) @(posedge clk);
        #1;
        chk({csr_address, csr_read, csr_write, csr_writedata} == '0, "reset_csr_outputs",
            {csr_address, csr_read, csr_write, csr_writedata}, 0);
        chk({cmd_ready, rsp_valid, rsp_status, rsp_rdata} == '0, "reset_rsp_outputs",
            {cmd_ready, rsp_valid, rsp_status, rsp_rdata}, 0);
        reset_n = 1'b1;

        run_cmd(0, 7'h50, 2, 32'h0000BEEF, 8'h00, 3, 0, 32'h0);
        run_cmd(1, 7'h50, 2, 32'h0, 8'h00, 1, 0, 32'h00003412);
        run_cmd(0, 7'h51, 1, 32'h000000A5, 8'h04, 0, 0, 32'h0);
        run_cmd(1, 7'h51, 3, 32'h0, 8'h0C, 2, 0, 32'h00776655);
        run_cmd(0, 7'h22, 1, 32'h0000005A, 8'h00, 0, 1, 32'h0);
        run_cmd(0, 7'h10, 0, 32'h0, 8'h00, 1, 0, 32'h0);
        run_cmd(1, 7'h11, 0, 32'h0, 8'h00, 0, 0, 32'hFFFFFFFF);
        run_cmd(1, 7'h12, 7, 32'h0, 8'h00, 2, 0, 32'hDDCCBBAA);
        run_cmd(0, 7'h13, 5, 32'h44332211, 8'h00, 0, 0, 32'h0);

        for (int t = 0; t < 30; t++) begin
            logic [7:0] isr_r;
            isr_r = isr_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) isr_r = 8'($urandom);
            run_cmd(1'($urandom), 7'($urandom), $urandom_range(0, 7), $urandom, isr_r,
                    $urandom_range(0, 4), ($urandom_range(0, 14) == 0), $urandom);
        end

        // Reset in the middle of the data phase.
        base = wr_seen;
        issue_cmd(0, 7'h33, 4, 32'hCAFEF00D, 8'h00, 2, 0, 32'h0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (wr_seen >= base + 3) break;
        end
        chk(wr_seen >= base + 3, "midreset_reach_data", wr_seen - base, 3);
        #1 reset_n = 1'b0;
        #1;
        chk({csr_read, csr_write, csr_address, csr_writedata} == '0, "midreset_csr_zero",
            {csr_read, csr_write, csr_address, csr_writedata}, 0);
        chk({cmd_ready, rsp_valid} == '0, "midreset_handshake_zero", {cmd_ready, rsp_valid}, 0);
        exp_wr.delete();
        exp_rsp.delete();
        push_init();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        run_cmd(1, 7'h50, 2, 32'h0, 8'h00, 1, 0, 32'h00003412);
        run_cmd(0, 7'h51, 2, 32'h00001234, 8'h04, 1, 0, 32'h0);

        repeat (5) @(posedge clk);
        chk(exp_wr.size() == 0, "csr_writes_leftover", exp_wr.size(), 0);
        chk(exp_rsp.size() == 0, "rsp_leftover", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
